// File: rtl/icache_ctrl.sv
// L1 instruction-cache controller: same-cycle 2-way lookup on hits, stalls IF and refills the LRU way from L2 on misses.
// Hit latency 0 cycles; miss delivers 3 cycles plus the L2 wait after the miss cycle. if_stall holds IF for the whole refill.
module icache_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic [31:0]      insn,
  output logic             if_stall,
  output logic             tag0_rw,
  output logic             tag1_rw,
  output logic [7:0]       index,
  output logic [19:0]      tag_wd,
  input  logic [20:0]      tag0_rd,
  input  logic [20:0]      tag1_rd,
  input  logic             lru,
  input  logic             complete,
  output logic             data0_rw,
  output logic             data1_rw,
  output logic [127:0]     data_wd,
  input  logic [127:0]     data0_rd,
  input  logic [127:0]     data1_rd,
  output logic             l2_req,
  output logic [31:0]      l2_addr,
  input  logic             l2_rdy,
  input  logic [127:0]     l2_data,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [1:0] LOOKUP    = 2'd0;
  localparam logic [1:0] L2_WAIT   = 2'd1;
  localparam logic [1:0] FILL      = 2'd2;
  localparam logic [1:0] WAIT_CMPL = 2'd3;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  logic [1:0]   state;
  logic [31:4]  miss_addr;
  logic         victim;
  logic [127:0] fill_buf;
  logic         hit0, hit1, hit;
  logic [127:0] blk;
  logic         unused_bits;

  assign hit0 = tag0_rd[20] && (tag0_rd[19:0] == if_addr[31:12]);
  assign hit1 = tag1_rd[20] && (tag1_rd[19:0] == if_addr[31:12]);
  assign hit  = hit0 | hit1;
  assign blk  = hit0 ? data0_rd : data1_rd;

  always_comb begin
    insn = blk[31:0];
    case (if_addr[3:2])
      2'd0: insn = blk[31:0];
      2'd1: insn = blk[63:32];
      2'd2: insn = blk[95:64];
      2'd3: insn = blk[127:96];
      default: insn = blk[31:0];
    endcase
  end

  assign if_stall = (state != LOOKUP) | (if_req & ~hit);
  // Outside LOOKUP the RAMs are addressed by the latched miss, so IF address churn is harmless.
  assign index    = (state == LOOKUP) ? if_addr[11:4] : miss_addr[11:4];
  assign tag_wd   = miss_addr[31:12];
  assign data_wd  = fill_buf;
  assign l2_req   = (state == L2_WAIT);
  assign l2_addr  = {miss_addr, 4'h0};

  assign tag0_rw  = (state == FILL && !victim) ? WRITE : READ;
  assign tag1_rw  = (state == FILL &&  victim) ? WRITE : READ;
  assign data0_rw = tag0_rw;
  assign data1_rw = tag1_rw;

  assign unused_bits = ^if_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOOKUP;
      miss_addr <= '0;
      victim    <= 1'b0;
      fill_buf  <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        LOOKUP: begin
          if (if_req && !hit) begin
            miss_addr <= if_addr[31:4];
            victim    <= lru;
            if (miss_cnt != {CNT_W{1'b1}})
              miss_cnt <= miss_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            state     <= L2_WAIT;
          end
        end
        L2_WAIT: begin
          if (l2_rdy) begin
            fill_buf <= l2_data;
            state    <= FILL;
          end
        end
        FILL: state <= WAIT_CMPL;
        WAIT_CMPL: begin
          // No timeout: a lost completion leaves IF stalled by design.
          if (complete)
            state <= LOOKUP;
        end
        default: state <= LOOKUP;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: tag/data RAM and L2 stand-ins, a cache-contents model predicting per-cycle outputs, randomized fetches.
module tb_icache_ctrl;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic clk = 1'b0;
  logic reset;
  logic if_req;
  logic [31:0] if_addr;
  logic [31:0] insn;
  logic if_stall, tag0_rw, tag1_rw, data0_rw, data1_rw;
  logic [7:0] index;
  logic [19:0] tag_wd;
  logic [20:0] tag0_rd, tag1_rd;
  logic lru, complete;
  logic [127:0] data_wd, data0_rd, data1_rd, l2_data;
  logic l2_req, l2_rdy;
  logic [31:0] l2_addr;
  logic [CW-1:0] miss_cnt;

  always #5 clk = ~clk;

  icache_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .insn(insn),
    .if_stall(if_stall), .tag0_rw(tag0_rw), .tag1_rw(tag1_rw), .index(index),
    .tag_wd(tag_wd), .tag0_rd(tag0_rd), .tag1_rd(tag1_rd), .lru(lru),
    .complete(complete), .data0_rw(data0_rw), .data1_rw(data1_rw),
    .data_wd(data_wd), .data0_rd(data0_rd), .data1_rd(data1_rd),
    .l2_req(l2_req), .l2_addr(l2_addr), .l2_rdy(l2_rdy), .l2_data(l2_data),
    .miss_cnt(miss_cnt)
  );

  // RAM stand-ins: tag_ram flips lru to the other way on fill and acks one cycle after the strobe.
  localparam logic [127:0] PRE0 = 128'h000000D3_000000D2_000000D1_000000D0;
  localparam logic [127:0] PRE1 = 128'h000000E3_000000E2_000000E1_000000E0;
  logic env_init;
  logic [20:0]  et0 [256];
  logic [20:0]  et1 [256];
  logic [127:0] ed0 [256];
  logic [127:0] ed1 [256];
  logic         el  [256];

  assign tag0_rd  = et0[index];
  assign tag1_rd  = et1[index];
  assign data0_rd = ed0[index];
  assign data1_rd = ed1[index];
  assign lru      = el[index];

  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 256; i++) begin
        et0[i] <= '0; et1[i] <= '0; ed0[i] <= '0; ed1[i] <= '0; el[i] <= 1'b0;
      end
      et0[8'hF0] <= {1'b1, 20'h0ABCD};
      et1[8'hF0] <= {1'b1, 20'h0ABCD};
      ed0[8'hF0] <= PRE0;
      ed1[8'hF0] <= PRE1;
      complete   <= 1'b0;
    end else begin
      complete <= tag0_rw | tag1_rw;
      if (tag0_rw) begin et0[index] <= {1'b1, tag_wd}; el[index] <= 1'b1; end
      if (tag1_rw) begin et1[index] <= {1'b1, tag_wd}; el[index] <= 1'b0; end
      if (data0_rw) ed0[index] <= data_wd;
      if (data1_rw) ed1[index] <= data_wd;
    end
  end

  // Reference model: what the cache must hold, and the miss count.
  bit           m_val0 [256];
  bit           m_val1 [256];
  logic [19:0]  m_tag0 [256];
  logic [19:0]  m_tag1 [256];
  logic [127:0] m_dat0 [256];
  logic [127:0] m_dat1 [256];
  bit           m_lru  [256];
  logic [CW-1:0] m_cnt;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per-cycle expectations, written by the driver, read by the compare process.
  bit chk_en;
  bit e_stall, e_ie, e_req, e_xe, e_fe;
  logic [31:0] e_insn, e_la;
  logic [1:0] e_wr;
  logic [7:0] e_idx;
  logic [19:0] e_tw;
  logic [127:0] e_dw;
  logic [CW-1:0] e_cnt;

  task automatic set_exp(input bit stall, input bit ie, input logic [31:0] ins, input bit req,
                         input logic [31:0] la, input logic [1:0] wr, input bit xe,
                         input logic [7:0] xi, input bit fe, input logic [19:0] tw,
                         input logic [127:0] dw);
    e_stall = stall; e_ie = ie; e_insn = ins; e_req = req; e_la = la; e_wr = wr;
    e_xe = xe; e_idx = xi; e_fe = fe; e_tw = tw; e_dw = dw;
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("if_stall", if_stall, e_stall);
      if (e_ie) chk("insn", insn, e_insn);
      chk("l2_req", l2_req, e_req);
      if (e_req) chk("l2_addr", l2_addr, e_la);
      chk("tag0_rw", tag0_rw, e_wr[0]);
      chk("tag1_rw", tag1_rw, e_wr[1]);
      chk("data0_rw", data0_rw, e_wr[0]);
      chk("data1_rw", data1_rw, e_wr[1]);
      if (e_xe) chk("index", index, e_idx);
      if (e_fe) begin
        chk("tag_wd", tag_wd, e_tw);
        chk("data_wd", data_wd, e_dw);
      end
      chk("miss_cnt", miss_cnt, e_cnt);
    end
  end

  // Observation summary used by the hand-computed directed checks.
  int mon_req_cyc, mon_wr_cyc, run, last_run;
  logic [31:0] mon_l2addr, last_insn;
  logic [7:0] mon_idx;
  logic [19:0] mon_tag;
  logic mon_way;

  always @(negedge clk) begin
    if (l2_req) begin mon_req_cyc++; mon_l2addr = l2_addr; end
    if (tag0_rw | tag1_rw) begin
      mon_wr_cyc++; mon_idx = index; mon_tag = tag_wd; mon_way = tag1_rw;
    end
    if (if_req && !reset) begin
      if (if_stall) run++;
      else begin last_insn = insn; last_run = run; run = 0; end
    end
  end

  task automatic mon_clr();
    mon_req_cyc = 0; mon_wr_cyc = 0; run = 0; last_run = -1;
    mon_l2addr = '0; last_insn = '0; mon_idx = '0; mon_tag = '0; mon_way = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if_req = 1'b0;
      if_addr = $urandom;
      set_exp(0, 0, 0, 0, 0, 2'b00, 1, if_addr[11:4], 0, 0, 0);
      step();
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int dly, input logic [127:0] d, input bit churn);
    logic [7:0] ix;
    logic [19:0] tg;
    logic [127:0] blk;
    bit v;
    ix = a[11:4];
    tg = a[31:12];
    if_req = 1'b1;
    if_addr = a;
    if (!((m_val0[ix] && m_tag0[ix] == tg) || (m_val1[ix] && m_tag1[ix] == tg))) begin
      v = m_lru[ix];
      set_exp(1, 0, 0, 0, 0, 2'b00, 1, ix, 0, 0, 0);
      step();
      if (m_cnt != CMAX) m_cnt++;
      e_cnt = m_cnt;
      for (int k = 1; k <= dly + 1; k++) begin
        if (churn) if_addr = $urandom;
        l2_rdy = (k == dly + 1);
        l2_data = (k == dly + 1) ? d : {$urandom, $urandom, $urandom, $urandom};
        set_exp(1, 0, 0, 1, {a[31:4], 4'h0}, 2'b00, 0, 0, 0, 0, 0);
        step();
      end
      l2_rdy = 1'b0;
      l2_data = {$urandom, $urandom, $urandom, $urandom};
      set_exp(1, 0, 0, 0, 0, v ? 2'b10 : 2'b01, 1, ix, 1, tg, d);
      step();
      set_exp(1, 0, 0, 0, 0, 2'b00, 1, ix, 0, 0, 0);
      step();
      if (v) begin m_val1[ix] = 1; m_tag1[ix] = tg; m_dat1[ix] = d; m_lru[ix] = 0; end
      else   begin m_val0[ix] = 1; m_tag0[ix] = tg; m_dat0[ix] = d; m_lru[ix] = 1; end
      if_addr = a;
    end
    blk = (m_val0[ix] && m_tag0[ix] == tg) ? m_dat0[ix] : m_dat1[ix];
    set_exp(0, 1, blk[a[3:2]*32 +: 32], 0, 0, 2'b00, 1, ix, 0, 0, 0);
    step();
  endtask

  logic [7:0]  idxs [3] = '{8'h23, 8'hF0, 8'h7A};
  logic [19:0] tags [4] = '{20'h00001, 20'h00002, 20'h00003, 20'h0ABCD};

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; l2_rdy = 1'b0; l2_data = '0;
    chk_en = 0; env_init = 1'b1;
    for (int i = 0; i < 256; i++) begin
      m_val0[i] = 0; m_val1[i] = 0; m_tag0[i] = '0; m_tag1[i] = '0;
      m_dat0[i] = '0; m_dat1[i] = '0; m_lru[i] = 0;
    end
    m_val0[8'hF0] = 1; m_tag0[8'hF0] = 20'h0ABCD; m_dat0[8'hF0] = PRE0;
    m_val1[8'hF0] = 1; m_tag1[8'hF0] = 20'h0ABCD; m_dat1[8'hF0] = PRE1;
    m_cnt = '0; e_cnt = '0;
    set_exp(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    mon_clr();
    step();
    env_init = 1'b0;
    #2;
    chk("rst_l2_req", l2_req, 0);
    chk("rst_l2_addr", l2_addr, 0);
    chk("rst_tag0_rw", tag0_rw, 0);
    chk("rst_data1_rw", data1_rw, 0);
    chk("rst_tag_wd", tag_wd, 0);
    chk("rst_data_wd", data_wd, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    step();
    reset = 1'b0;
    chk_en = 1;
    idle(2);
    chk("idle_stall", if_stall, 0);

    // Cold miss into way0, then a same-block hit.
    mon_clr();
    fetch(32'h0000_1234, 0, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 0);
    chk("cold_l2_addr", mon_l2addr, 32'h0000_1230);
    chk("cold_req_cycles", mon_req_cyc, 1);
    chk("cold_wr_cycles", mon_wr_cyc, 1);
    chk("cold_index", mon_idx, 8'h23);
    chk("cold_tag_wd", mon_tag, 20'h00001);
    chk("cold_way", mon_way, 0);
    chk("cold_insn", last_insn, 32'h2222_2222);
    chk("cold_latency", last_run, 4);
    chk("cold_miss_cnt", miss_cnt, 1);
    mon_clr();
    fetch(32'h0000_123C, 0, 0, 0);
    chk("hit_insn", last_insn, 32'h4444_4444);
    chk("hit_latency", last_run, 0);
    chk("hit_no_l2", mon_req_cyc, 0);

    // Conflict misses on index 0x23.
    mon_clr();
    fetch(32'h0000_2230, 0, {$urandom, $urandom, $urandom, $urandom}, 0);
    chk("conf1_way", mon_way, 1);
    mon_clr();
    fetch(32'h0000_1234, 0, 0, 0);
    fetch(32'h0000_2230, 0, 0, 0);
    chk("conf_both_hit", mon_req_cyc, 0);
    mon_clr();
    fetch(32'h0000_3230, 1, {$urandom, $urandom, $urandom, $urandom}, 0);
    chk("conf2_way", mon_way, 0);
    mon_clr();
    fetch(32'h0000_1234, 0, {$urandom, $urandom, $urandom, $urandom}, 0);
    chk("evicted_miss", mon_req_cyc, 1);

    // Slow L2 while IF address churns.
    mon_clr();
    fetch(32'h0000_4560, 7, {$urandom, $urandom, $urandom, $urandom}, 1);
    chk("slow_req_cycles", mon_req_cyc, 8);
    chk("slow_l2_addr", mon_l2addr, 32'h0000_4560);
    chk("slow_latency", last_run, 11);

    // Both ways holding the same tag: way0 must win.
    fetch(32'h0ABC_DF08, 0, 0, 0);
    chk("both_hit_way0", last_insn, 32'h0000_00D2);

    // Reset while waiting on L2; the late l2_rdy must be ignored.
    mon_clr();
    a = 32'h0005_5550;
    if_req = 1'b1; if_addr = a;
    set_exp(1, 0, 0, 0, 0, 2'b00, 1, 8'h55, 0, 0, 0);
    step();
    if (m_cnt != CMAX) m_cnt++;
    e_cnt = m_cnt;
    set_exp(1, 0, 0, 1, a, 2'b00, 0, 0, 0, 0, 0);
    step();
    chk_en = 0;
    if_req = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("arst_l2_req", l2_req, 0);
    chk("arst_l2_addr", l2_addr, 0);
    chk("arst_miss_cnt", miss_cnt, 0);
    chk("arst_stall", if_stall, 0);
    chk("arst_tag_wd", tag_wd, 0);
    step();
    step();
    reset = 1'b0;
    m_cnt = '0; e_cnt = '0;
    chk_en = 1;
    l2_rdy = 1'b1; l2_data = {$urandom, $urandom, $urandom, $urandom};
    set_exp(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step();
    l2_rdy = 1'b0;
    idle(3);
    chk("rst_no_strobe", mon_wr_cyc, 0);
    mon_clr();
    fetch(a, 1, {$urandom, $urandom, $urandom, $urandom}, 0);
    chk("rst_refetch_miss", mon_req_cyc, 2);
    chk("rst_refetch_cnt", miss_cnt, 1);

    // Randomized traffic over a few contended sets; drives miss_cnt into saturation.
    for (int n = 0; n < 250; n++) begin
      w = $urandom_range(0, 3);
      a = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 2)], w[1:0], 2'b00};
      fetch(a, $urandom_range(0, 4), {$urandom, $urandom, $urandom, $urandom}, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
